branch_hazard_ctrl: RTL and testbench

Sequencing controller for the ID-stage branch unit. It detects RAW hazards on branch operands, drives the operand forwarding selects, stalls the front end while a load result is outstanding, and registers taken-branch redirects with a one-cycle IF/ID flush. It also keeps performance counters. It sits between the decoder/pipeline registers and the branch unit, PC and instCache.

---
 rtl/branch_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage branch hazard detection, forwarding selects, load stalls,
// registered taken-branch redirect with one-cycle IF/ID flush, and saturating perf counters.
`default_nettype none

module branch_hazard_ctrl #(
    parameter int XLEN      = 32,
    parameter int REG_W     = 5,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idValid,
    input  logic [6:0]       idOpcode,
    input  logic [REG_W-1:0] idRs1,
    input  logic [REG_W-1:0] idRs2,
    input  logic [REG_W-1:0] exRd,
    input  logic             exRegWrite,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] memRd,
    input  logic             memRegWrite,
    input  logic             memMemRead,
    input  logic             branchFlag,
    input  logic [XLEN-1:0]  branchAddr,
    output logic [1:0]       select1,
    output logic [1:0]       select2,
    output logic             pcStall,
    output logic             ifIdStall,
    output logic             idExBubble,
    output logic             redirectValid,
    output logic [XLEN-1:0]  redirectPc,
    output logic             ifIdFlush,
    output logic [CNT_W-1:0] branchCnt,
    output logic [CNT_W-1:0] takenCnt,
    output logic [CNT_W-1:0] stallCycCnt,
    output logic             stallErr
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int         RUN_W     = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] stall_run;
    logic [RUN_W:0]   run_inc;
    logic             is_br;
    logic             ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic             load_haz;
    logic             active;
    logic             stall_now;

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                           input logic ex_load, input logic mem_load);
        if (ex_hit && !ex_load)
            return 2'b01;
        else if (mem_hit && !mem_load)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        is_br     = idValid && (idOpcode == OP_BRANCH);
        ex_hit1   = exRegWrite && (exRd == idRs1) && (idRs1 != '0);
        ex_hit2   = exRegWrite && (exRd == idRs2) && (idRs2 != '0);
        mem_hit1  = memRegWrite && (memRd == idRs1) && (idRs1 != '0);
        mem_hit2  = memRegWrite && (memRd == idRs2) && (idRs2 != '0);
        load_haz  = is_br && ((exMemRead && (ex_hit1 || ex_hit2)) ||
                              (memMemRead && (mem_hit1 || mem_hit2)));
        // The ID instruction during REDIRECT is wrong-path and must not influence anything.
        active    = (state != REDIRECT);
        stall_now = active && load_haz;
        run_inc   = {1'b0, stall_run} + 1'b1;
    end

    // Strobes are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        select1       = 2'b00;
        select2       = 2'b00;
        if (rst_n && active && is_br) begin
            select1 = fwd_sel(ex_hit1, mem_hit1, exMemRead, memMemRead);
            select2 = fwd_sel(ex_hit2, mem_hit2, exMemRead, memMemRead);
        end
        pcStall       = rst_n && stall_now;
        ifIdStall     = rst_n && stall_now;
        idExBubble    = rst_n && stall_now;
        redirectValid = rst_n && (state == REDIRECT);
        ifIdFlush     = rst_n && (state == REDIRECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stall_run   <= '0;
            redirectPc  <= '0;
            branchCnt   <= '0;
            takenCnt    <= '0;
            stallCycCnt <= '0;
            stallErr    <= 1'b0;
        end else begin
            case (state)
                IDLE, STALL: begin
                    if (load_haz) begin
                        state       <= STALL;
                        stallCycCnt <= sat_inc(stallCycCnt);
                        if (run_inc <= (RUN_W + 1)'(MAX_STALL))
                            stall_run <= run_inc[RUN_W-1:0];
                        if (run_inc >= (RUN_W + 1)'(MAX_STALL))
                            stallErr <= 1'b1;
                    end else if (is_br) begin
                        branchCnt <= sat_inc(branchCnt);
                        stall_run <= '0;
                        if (branchFlag) begin
                            takenCnt   <= sat_inc(takenCnt);
                            redirectPc <= branchAddr;
                            state      <= REDIRECT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state     <= IDLE;
                        stall_run <= '0;
                    end
                end
                REDIRECT: begin
                    state     <= IDLE;
                    stall_run <= '0;
                end
                default: begin
                    state     <= IDLE;
                    stall_run <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed checks of branch_hazard_ctrl, plus a 2-bit-counter
// instance sharing the same stimulus to exercise counter saturation.
`default_nettype none

module tb_branch_hazard_ctrl;

    localparam logic [6:0] OP_BR = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idValid;
    logic [6:0]  idOpcode;
    logic [4:0]  idRs1, idRs2, exRd, memRd;
    logic        exRegWrite, exMemRead, memRegWrite, memMemRead;
    logic        branchFlag;
    logic [31:0] branchAddr;

    logic [1:0]  select1, select2;
    logic        pcStall, ifIdStall, idExBubble, redirectValid, ifIdFlush, stallErr;
    logic [31:0] redirectPc;
    logic [15:0] branchCnt, takenCnt, stallCycCnt;

    logic [1:0]  s_select1, s_select2;
    logic        s_pcStall, s_ifIdStall, s_idExBubble, s_redirectValid, s_ifIdFlush, s_stallErr;
    logic [31:0] s_redirectPc;
    logic [1:0]  s_branchCnt, s_takenCnt, s_stallCycCnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .idValid(idValid), .idOpcode(idOpcode),
        .idRs1(idRs1), .idRs2(idRs2), .exRd(exRd), .exRegWrite(exRegWrite),
        .exMemRead(exMemRead), .memRd(memRd), .memRegWrite(memRegWrite),
        .memMemRead(memMemRead), .branchFlag(branchFlag), .branchAddr(branchAddr),
        .select1(select1), .select2(select2), .pcStall(pcStall), .ifIdStall(ifIdStall),
        .idExBubble(idExBubble), .redirectValid(redirectValid), .redirectPc(redirectPc),
        .ifIdFlush(ifIdFlush), .branchCnt(branchCnt), .takenCnt(takenCnt),
        .stallCycCnt(stallCycCnt), .stallErr(stallErr)
    );

    branch_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .idValid(idValid), .idOpcode(idOpcode),
        .idRs1(idRs1), .idRs2(idRs2), .exRd(exRd), .exRegWrite(exRegWrite),
        .exMemRead(exMemRead), .memRd(memRd), .memRegWrite(memRegWrite),
        .memMemRead(memMemRead), .branchFlag(branchFlag), .branchAddr(branchAddr),
        .select1(s_select1), .select2(s_select2), .pcStall(s_pcStall), .ifIdStall(s_ifIdStall),
        .idExBubble(s_idExBubble), .redirectValid(s_redirectValid), .redirectPc(s_redirectPc),
        .ifIdFlush(s_ifIdFlush), .branchCnt(s_branchCnt), .takenCnt(s_takenCnt),
        .stallCycCnt(s_stallCycCnt), .stallErr(s_stallErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        idValid = 0; idOpcode = 0; idRs1 = 0; idRs2 = 0;
        exRd = 0; exRegWrite = 0; exMemRead = 0;
        memRd = 0; memRegWrite = 0; memMemRead = 0;
        branchFlag = 0; branchAddr = 0;
    endtask

    task automatic br(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic flag, input logic [31:0] addr);
        idValid = 1; idOpcode = OP_BR; idRs1 = rs1; idRs2 = rs2;
        branchFlag = flag; branchAddr = addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        #3;
        chk("rst_pcStall", pcStall, 0);
        chk("rst_redirectValid", redirectValid, 0);
        chk("rst_redirectPc", redirectPc, 0);
        chk("rst_branchCnt", branchCnt, 0);
        chk("rst_stallErr", stallErr, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Taken BEQ x1,x2 without producers
        clear_in(); br(1, 2, 1, 32'h40); #1;
        chk("beq_noStall", pcStall, 0);
        chk("beq_sel1", select1, 0);
        chk("beq_noRedirYet", redirectValid, 0);
        tick(); clear_in(); #1;
        chk("beq_redirValid", redirectValid, 1);
        chk("beq_flush", ifIdFlush, 1);
        chk("beq_redirPc", redirectPc, 32'h40);
        chk("beq_branchCnt", branchCnt, 1);
        chk("beq_takenCnt", takenCnt, 1);
        tick();
        chk("beq_idleAfter", redirectValid, 0);
        chk("beq_flushDrop", ifIdFlush, 0);

        // Forwarding priority: EX beats MEM, then MEM alone
        clear_in(); br(1, 3, 0, 0);
        exRd = 1; exRegWrite = 1; memRd = 1; memRegWrite = 1; #1;
        chk("fwd_sel1_ex", select1, 2'b01);
        chk("fwd_sel2", select2, 2'b00);
        chk("fwd_noStall", pcStall, 0);
        exRegWrite = 0; #1;
        chk("fwd_sel1_mem", select1, 2'b10);
        tick();
        chk("fwd_branchCnt", branchCnt, 2);
        chk("fwd_noRedir", redirectValid, 0);

        // Load to x2 in EX, BLT x5,x2: two stall cycles
        clear_in(); br(5, 2, 0, 0);
        exRd = 2; exRegWrite = 1; exMemRead = 1; #1;
        chk("ld_stall1_pc", pcStall, 1);
        chk("ld_stall1_ifid", ifIdStall, 1);
        chk("ld_stall1_bubble", idExBubble, 1);
        tick();
        exRd = 0; exRegWrite = 0; exMemRead = 0;
        memRd = 2; memRegWrite = 1; memMemRead = 1; #1;
        chk("ld_stall2_bubble", idExBubble, 1);
        chk("ld_stall2_sel2", select2, 0);
        tick();
        memRd = 0; memRegWrite = 0; memMemRead = 0; #1;
        chk("ld_resolve_noStall", pcStall, 0);
        chk("ld_resolve_noBubble", idExBubble, 0);
        tick();
        chk("ld_stallCyc", stallCycCnt, 2);
        chk("ld_branchCnt", branchCnt, 3);
        chk("ld_stallErr", stallErr, 0);
        chk("sat_branchCnt3", s_branchCnt, 3);

        // Branch on x0 with a load writing x0 pending
        clear_in(); br(0, 0, 0, 0);
        exRd = 0; exRegWrite = 1; exMemRead = 1; #1;
        chk("x0_noStall", pcStall, 0);
        chk("x0_sel1", select1, 0);
        chk("x0_sel2", select2, 0);
        tick();
        chk("x0_branchCnt", branchCnt, 4);
        chk("sat_branchCnt_noWrap", s_branchCnt, 3);

        // Second taken branch presented during REDIRECT is ignored
        clear_in(); br(1, 2, 1, 32'h80); #1;
        tick();
        br(1, 3, 1, 32'h100); exRd = 1; exRegWrite = 1; #1;
        chk("rd_sel1_forced", select1, 0);
        chk("rd_redirValid", redirectValid, 1);
        chk("rd_redirPc", redirectPc, 32'h80);
        chk("rd_noStall", pcStall, 0);
        tick();
        clear_in(); #1;
        chk("rd_noSecondRedir", redirectValid, 0);
        chk("rd_redirPcKept", redirectPc, 32'h80);
        chk("rd_branchCnt", branchCnt, 5);
        chk("rd_takenCnt", takenCnt, 2);
        chk("sat_takenCnt", s_takenCnt, 2);

        // Persistent load hazard for 4 cycles: stallErr after the third
        clear_in(); br(1, 0, 0, 0);
        exRd = 1; exRegWrite = 1; exMemRead = 1; #1;
        tick();
        chk("err_c1", stallErr, 0);
        tick();
        chk("err_c2", stallErr, 0);
        tick();
        chk("err_c3", stallErr, 1);
        tick();
        chk("err_c4", stallErr, 1);
        chk("err_stallCyc", stallCycCnt, 6);
        chk("sat_stallCyc", s_stallCycCnt, 3);
        chk("err_stillStall", pcStall, 1);
        idValid = 0; #1;
        chk("err_flushNoStall", pcStall, 0);
        tick();
        chk("err_sticky", stallErr, 1);

        // Reset asserted mid-stall
        clear_in(); br(1, 0, 0, 0);
        exRd = 1; exRegWrite = 1; exMemRead = 1; exRegWrite = 1;
        tick();
        chk("mid_stallCyc", stallCycCnt, 7);
        chk("mid_stalling", pcStall, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_pcStall", pcStall, 0);
        chk("mid_rst_bubble", idExBubble, 0);
        chk("mid_rst_stallErr", stallErr, 0);
        chk("mid_rst_stallCyc", stallCycCnt, 0);
        chk("mid_rst_branchCnt", branchCnt, 0);
        chk("mid_rst_redirPc", redirectPc, 0);
        #3 rst_n = 1;
        clear_in(); br(0, 0, 1, 32'hC0); #1;
        tick();
        clear_in(); #1;
        chk("post_rst_redir", redirectValid, 1);
        chk("post_rst_redirPc", redirectPc, 32'hC0);
        chk("post_rst_branchCnt", branchCnt, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
